// File: rtl/usb_rcv_ctrl.sv
// USB receive control: SYNC check, per-byte FIFO write strobes,
// EOP framing and overlength error detection.
module usb_rcv_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [6:0] pkt_bytes
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        RCV      = 3'd2,
        STORE    = 3'd3,
        FULL     = 3'd4,
        ERR_WAIT = 3'd5,
        EOP_DONE = 3'd6,
        ERR_EOP  = 3'd7
    } state_t;

    localparam logic [6:0] MAX_B = 7'(MAX_BYTES);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rcving_q, rcving_d;
    logic       w_enable_q, w_enable_d;
    logic       r_error_q, r_error_d;
    logic [6:0] pkt_bytes_q, pkt_bytes_d;
    logic       eop_s;

    assign eop_s = eop & shift_enable;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        r_error_d   = r_error_q;
        pkt_bytes_d = pkt_bytes_q;

        unique case (state_q)
            IDLE: begin
                if (d_edge) begin
                    state_d     = SYNC;
                    r_error_d   = 1'b0;
                    pkt_bytes_d = '0;
                    bit_cnt_d   = '0;
                end
            end
            SYNC: begin
                if (byte_received) begin
                    bit_cnt_d = '0;
                    if (rcv_data == SYNC_BYTE) begin
                        state_d = RCV;
                    end else begin
                        state_d   = ERR_WAIT;
                        r_error_d = 1'b1;
                    end
                end else if (eop_s) begin
                    state_d   = ERR_EOP;
                    r_error_d = 1'b1;
                end
            end
            RCV: begin
                if (byte_received) begin
                    state_d   = STORE;
                    bit_cnt_d = '0;
                    // Count on entry so pkt_bytes already shows the new total in STORE
                    if (pkt_bytes_q < MAX_B) begin
                        pkt_bytes_d = pkt_bytes_q + 7'd1;
                    end
                end else if (eop_s) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = EOP_DONE;
                    end else begin
                        state_d   = ERR_EOP;
                        r_error_d = 1'b1;
                    end
                end else if (shift_enable) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STORE: begin
                if (pkt_bytes_q == MAX_B) begin
                    state_d = FULL;
                end else begin
                    state_d = RCV;
                end
            end
            FULL: begin
                if (byte_received) begin
                    state_d   = ERR_WAIT;
                    r_error_d = 1'b1;
                end else if (eop_s) begin
                    state_d = EOP_DONE;
                end
            end
            ERR_WAIT: begin
                if (eop_s) begin
                    state_d   = ERR_EOP;
                    r_error_d = 1'b1;
                end
            end
            EOP_DONE, ERR_EOP: begin
                if (d_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they line up with the state register
    always_comb begin
        rcving_d   = 1'b0;
        w_enable_d = 1'b0;
        unique case (state_d)
            SYNC, RCV, FULL, ERR_WAIT: rcving_d = 1'b1;
            STORE: begin
                rcving_d   = 1'b1;
                w_enable_d = 1'b1;
            end
            default: rcving_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rcving_q    <= 1'b0;
            w_enable_q  <= 1'b0;
            r_error_q   <= 1'b0;
            pkt_bytes_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rcving_q    <= rcving_d;
            w_enable_q  <= w_enable_d;
            r_error_q   <= r_error_d;
            pkt_bytes_q <= pkt_bytes_d;
        end
    end

    assign rcving    = rcving_q;
    assign w_enable  = w_enable_q;
    assign r_error   = r_error_q;
    assign pkt_bytes = pkt_bytes_q;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Directed bench for usb_rcv_ctrl with MAX_BYTES=4.
module tb_usb_rcv_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [6:0] pkt_bytes;

    int tests = 0;
    int failed = 0;
    int wcnt = 0;
    int b2b = 0;
    int w0;
    logic w_prev = 1'b0;

    localparam int S_IDLE = 0, S_SYNC = 1, S_RCV = 2, S_STORE = 3;
    localparam int S_FULL = 4, S_ERRW = 5, S_EOPD = 6, S_ERRE = 7;

    usb_rcv_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(4)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .d_edge(d_edge),
        .eop(eop),
        .shift_enable(shift_enable),
        .byte_received(byte_received),
        .rcv_data(rcv_data),
        .rcving(rcving),
        .w_enable(w_enable),
        .r_error(r_error),
        .pkt_bytes(pkt_bytes)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_enable) wcnt = wcnt + 1;
        if (w_enable && w_prev) b2b = b2b + 1;
        w_prev = w_enable;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_pulse();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rcv_data = b;
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
    endtask

    task automatic shift();
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
    endtask

    task automatic eop_strobe();
        eop = 1'b1;
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
    endtask

    task automatic eop_end();
        eop = 1'b0;
        edge_pulse();
    endtask

    initial begin
        tick();
        tick();
        check("rst_rcving", int'(rcving), 0);
        check("rst_wen", int'(w_enable), 0);
        check("rst_rerr", int'(r_error), 0);
        check("rst_pkt", int'(pkt_bytes), 0);
        n_rst = 1'b1;
        tick();

        // 1: good packet
        w0 = wcnt;
        edge_pulse();
        check("t1_sync_rcving", int'(rcving), 1);
        send_byte(8'h80);
        check("t1_sync_state", int'(dut.state_q), S_RCV);
        check("t1_sync_wen", int'(w_enable), 0);
        send_byte(8'hA5);
        check("t1_b1_wen", int'(w_enable), 1);
        check("t1_b1_pkt", int'(pkt_bytes), 1);
        tick();
        check("t1_b1_wen_off", int'(w_enable), 0);
        send_byte(8'h3C);
        check("t1_b2_wen", int'(w_enable), 1);
        tick();
        eop_strobe();
        check("t1_eop_rcving", int'(rcving), 0);
        check("t1_eop_state", int'(dut.state_q), S_EOPD);
        check("t1_pkt", int'(pkt_bytes), 2);
        check("t1_rerr", int'(r_error), 0);
        check("t1_wcnt", wcnt - w0, 2);
        eop_end();
        check("t1_idle", int'(dut.state_q), S_IDLE);

        // 2: bad SYNC
        w0 = wcnt;
        edge_pulse();
        send_byte(8'h81);
        check("t2_rerr", int'(r_error), 1);
        check("t2_state", int'(dut.state_q), S_ERRW);
        send_byte(8'hA5);
        tick();
        check("t2_wcnt", wcnt - w0, 0);
        eop_strobe();
        check("t2_eop_state", int'(dut.state_q), S_ERRE);
        eop_end();
        check("t2_idle", int'(dut.state_q), S_IDLE);
        check("t2_idle_rerr", int'(r_error), 1);
        tick();
        check("t2_idle_rerr_hold", int'(r_error), 1);

        // 3: premature EOP (packet starts with this edge)
        w0 = wcnt;
        edge_pulse();
        check("t3_rerr_clr", int'(r_error), 0);
        send_byte(8'h80);
        send_byte(8'h11);
        tick();
        shift();
        shift();
        shift();
        eop_strobe();
        check("t3_rerr", int'(r_error), 1);
        check("t3_rcving", int'(rcving), 0);
        check("t3_pkt", int'(pkt_bytes), 1);
        check("t3_wcnt", wcnt - w0, 1);
        eop_end();

        // 4: overlength
        w0 = wcnt;
        edge_pulse();
        send_byte(8'h80);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h10 + 8'(i));
            tick();
        end
        check("t4_full_state", int'(dut.state_q), S_FULL);
        check("t4_pkt", int'(pkt_bytes), 4);
        check("t4_wcnt", wcnt - w0, 4);
        check("t4_rerr_pre", int'(r_error), 0);
        send_byte(8'h55);
        check("t4_rerr", int'(r_error), 1);
        tick();
        check("t4_wcnt_after", wcnt - w0, 4);
        check("t4_pkt_sat", int'(pkt_bytes), 4);
        eop_strobe();
        eop_end();

        // 4b: EOP at exactly MAX bytes
        edge_pulse();
        send_byte(8'h80);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h20 + 8'(i));
            tick();
        end
        eop_strobe();
        check("t4b_state", int'(dut.state_q), S_EOPD);
        check("t4b_rerr", int'(r_error), 0);
        check("t4b_rcving", int'(rcving), 0);
        eop_end();

        // 5: reset mid-packet
        edge_pulse();
        send_byte(8'h80);
        send_byte(8'h22);
        tick();
        check("t5_pre_state", int'(dut.state_q), S_RCV);
        w0 = wcnt;
        #2;
        n_rst = 1'b0;
        #1;
        check("t5_rst_rcving", int'(rcving), 0);
        check("t5_rst_wen", int'(w_enable), 0);
        check("t5_rst_rerr", int'(r_error), 0);
        check("t5_rst_pkt", int'(pkt_bytes), 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        check("t5_wcnt", wcnt - w0, 0);
        check("t5_idle", int'(dut.state_q), S_IDLE);
        edge_pulse();
        send_byte(8'h80);
        send_byte(8'h5A);
        check("t5_wen", int'(w_enable), 1);
        tick();
        eop_strobe();
        check("t5_state", int'(dut.state_q), S_EOPD);
        check("t5_pkt", int'(pkt_bytes), 1);
        check("t5_rerr", int'(r_error), 0);
        eop_end();

        // 6: byte_received and eop_s in the same cycle
        edge_pulse();
        send_byte(8'h80);
        rcv_data = 8'h77;
        byte_received = 1'b1;
        eop = 1'b1;
        shift_enable = 1'b1;
        tick();
        byte_received = 1'b0;
        shift_enable = 1'b0;
        check("t6_state", int'(dut.state_q), S_STORE);
        check("t6_wen", int'(w_enable), 1);
        check("t6_rerr", int'(r_error), 0);
        tick();
        eop_strobe();
        check("t6_eop_state", int'(dut.state_q), S_EOPD);
        check("t6_eop_rerr", int'(r_error), 0);
        check("t6_pkt", int'(pkt_bytes), 1);
        eop_end();
        check("t6_idle", int'(dut.state_q), S_IDLE);

        tick();
        check("b2b_wen", b2b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/usb_rcv_ctrl.md
Name: usb_rcv_ctrl

Overview:
Receive control unit for the USB receiver. It sequences the bit/byte timer and shift register. It enables the timer via `rcving`, validates the SYNC byte, issues one-cycle FIFO write strobes per data byte, and detects EOP framing, premature EOP and overlength errors. It sits between the edge/EOP detectors plus timer on the input side and the RX FIFO on the output side.

Parameters:
SYNC_BYTE, 8'h80, required value of the first received byte (shift-register view).
MAX_BYTES, 64, maximum data bytes per packet (SYNC excluded); must be 1..127.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
d_edge  input  1  one-cycle pulse on any D+/D- transition
eop  input  1  EOP (SE0) currently present on the line
shift_enable  input  1  one-cycle bit-sample strobe from timer
byte_received  input  1  one-cycle pulse: 8 bits shifted, rcv_data valid
rcv_data  input  8  parallel byte from shift register
rcving  output  1  packet in progress; drives timer enable and clears its byte counter when low
w_enable  output  1  one-cycle FIFO write strobe for rcv_data
r_error  output  1  sticky receive error flag
pkt_bytes  output  7  data bytes written in current/last packet

Behaviour:
- Reset (async, n_rst=0): state=IDLE; rcving=0, w_enable=0, r_error=0, pkt_bytes=0; internal bit counter=0. Reset mid-packet aborts immediately. No FIFO write follows reset.
- All outputs are registered or decoded from registered state. No combinational input-to-output paths.
- EOP strobe: eop_s = eop & shift_enable.
- Bit counter: 3-bit. Increments on shift_enable while in RCV. Cleared on byte_received and on entry to SYNC.
- IDLE: rcving=0; r_error holds its value. On d_edge: go to SYNC, clear r_error and pkt_bytes. The first cycle in SYNC has rcving=1.
- SYNC: rcving=1.
  - On byte_received: if rcv_data==SYNC_BYTE, go to RCV; otherwise set r_error and go to ERR_WAIT.
  - Else if eop_s: set r_error and go to ERR_EOP.
- RCV: rcving=1.
  - On byte_received: go to STORE.
  - Else if eop_s: if bit counter==0 (byte boundary), go to EOP_DONE; otherwise set r_error and go to ERR_EOP.
- STORE (exactly 1 cycle): w_enable=1 and pkt_bytes increments.
  - If the new pkt_bytes==MAX_BYTES, go to FULL.
  - Otherwise go to RCV.
- FULL: rcving=1; waits for the packet end, no writes.
  - Any byte_received: set r_error and go to ERR_WAIT.
  - eop_s: go to EOP_DONE (no error).
- ERR_WAIT: rcving=1; ignore bytes, no writes. On eop_s, go to ERR_EOP.
- EOP_DONE / ERR_EOP: rcving=0. On d_edge (SE0 to J transition ending EOP), go to IDLE.
- Priority when byte_received and eop_s coincide: byte_received wins.
- w_enable is never high for 2 consecutive cycles and is never high outside STORE.
- pkt_bytes saturates at MAX_BYTES; it holds after the packet until the next SYNC entry.
- r_error sets only on entry to ERR_WAIT/ERR_EOP and clears only on the IDLE to SYNC transition. It is therefore visible to the host through IDLE.
- A d_edge pulse in any state other than IDLE, EOP_DONE or ERR_EOP is ignored by the FSM.
- Encoding: 3-bit state register; all unused codes go to IDLE.

Test Plan:
1. Good packet: d_edge, byte 8'h80, data 8'hA5, 8'h3C, then eop_s at boundary, then d_edge. Required:
   - exactly 2 w_enable pulses, each 1 cycle, each 1 cycle after its byte_received;
   - pkt_bytes=2, r_error=0;
   - rcving falls the cycle after eop_s;
   - state returns to IDLE after the d_edge.
2. Bad SYNC: first byte 8'h81. Required:
   - r_error=1 the cycle after byte_received;
   - following bytes produce no w_enable;
   - after eop_s and d_edge, r_error stays 1 in IDLE;
   - the next packet's first d_edge clears r_error.
3. Premature EOP: SYNC ok, 1 data byte, 3 shift_enables, then eop_s. Required: r_error=1, rcving=0, 1 w_enable total, pkt_bytes=1.
4. Overlength with MAX_BYTES=4: SYNC plus 5 data bytes. Required:
   - 4 w_enables, pkt_bytes=4;
   - the 5th byte sets r_error;
   - an EOP at exactly 4 bytes instead gives r_error=0.
5. Reset mid-packet: n_rst low during RCV, 2 cycles after byte_received. Required:
   - all outputs 0 asynchronously, no w_enable;
   - next packet decodes normally.
6. Coincident byte_received and eop_s in RCV. Required: STORE taken (w_enable=1), no error; the later eop_s at boundary ends the packet cleanly.
